pcf8591_txn_scheduler: RTL and testbench
========================================

Name: pcf8591_txn_scheduler

Overview:
Shares one PCF8591 between two requesters: DAC output updates (lock-in reference/excitation) and ADC sample reads (demodulator input). Arbitrates the requests and turns each one into a sequence of byte-level commands for the I2C byte master. Retries NACKed transactions and reports errors. Sits between the lock-in datapath and the I2C master, which drives sda/scl.

Parameters:
DEV_ADDR, 7'h48, 7-bit PCF8591 slave address.
MAX_RETRY, 2, re-attempts after a NACK before a transaction is abandoned (0..7).

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
dac_valid  in  1  DAC update request
dac_data  in  8  DAC code
dac_ready  out  1  DAC request accepted this cycle
adc_valid  in  1  ADC sample request
adc_ch  in  2  ADC channel
adc_ready  out  1  ADC request accepted this cycle
adc_rsp_valid  out  1  one-cycle pulse, adc_data valid
adc_data  out  8  sampled code
err  out  1  one-cycle pulse, transaction abandoned
busy  out  1  a transaction is in progress
cmd_valid  out  1  command to I2C master
cmd_op  out  2  0 START, 1 WRITE, 2 READ, 3 STOP
cmd_wdata  out  8  byte for WRITE
cmd_nack  out  1  READ: master sends NACK (last byte)
cmd_ready  in  1  master accepts command
rsp_valid  in  1  command completed (one pulse per command)
rsp_nack  in  1  WRITE: slave NACKed (valid with rsp_valid)
rsp_rdata  in  8  READ byte (valid with rsp_valid)

Behaviour:
- Reset values: all outputs 0; FSM IDLE; rr_last=ADC, so DAC wins the first tie; retry count 0. A reset mid-transaction aborts immediately. No STOP is issued; the I2C master is reset by the same reset.
- Handshakes: request accepted when valid&&ready. ready is asserted only in IDLE, combinationally, for the arbitration winner only. dac_data/adc_ch are latched on accept.
- Arbitration in IDLE: if only one request is pending, it wins. If both are pending, round-robin: the winner is the type not served last. rr_last updates on accept.
- Command protocol: cmd_valid and its fields are held stable until cmd_ready. The FSM then waits for rsp_valid before issuing the next command. Only one command is outstanding at a time.
- DAC sequence: START -> WRITE {DEV_ADDR,0} -> WRITE 8'h40 (analog-out enable) -> WRITE data -> STOP.
- ADC sequence: START -> WRITE {DEV_ADDR,0} -> WRITE {6'b010000,ch} -> START (repeated) -> WRITE {DEV_ADDR,1} -> READ nack=0 (stale previous conversion, discarded) -> READ nack=1 -> STOP.
- ADC result: adc_rsp_valid pulses the cycle after the STOP's rsp_valid. adc_data = byte from the second READ; adc_data holds until the next pulse.
- FSM states: IDLE, ISSUE (drive cmd), WAIT (await rsp), NEXT (step index / select following op), DONE, ERR_STOP. A 3-bit step index plus a type bit select op/data.
- NACK on any WRITE: go to ERR_STOP, issue STOP.
  - If retry count < MAX_RETRY: increment it and restart the sequence at step 0 with the latched request.
  - Else: pulse err one cycle after the STOP's rsp_valid, clear the retry count, return to IDLE. No adc_rsp_valid for an abandoned ADC request.
- rsp_nack is ignored for START/STOP/READ.
- busy = (state != IDLE). busy deasserts the cycle after DONE/err.
- Requests arriving while busy stay pending: the requester holds valid. No queueing.
- Spurious rsp_valid while in ISSUE/IDLE is ignored.
- MAX_RETRY=0: the first NACK abandons the transaction.

Decomposition:
- Package pcf8591_pkg holds:
  - cmd_op encodings (OP_START/WRITE/READ/STOP).
  - CTRL_DAC_EN=8'h40 and CTRL_ADC_BASE=8'h40.
  - The FSM state enum.
  - The request-type enum (REQ_DAC, REQ_ADC).
- One natural sub-module, pcf8591_seq_rom: combinational map of (type, step) -> {op, wdata_sel, nack, last}. It keeps the FSM generic.

Test Plan:
- DAC only, dac_data=8'hA5, master with cmd_ready=1 and rsp 2 cycles later -> ops START, W 8'h90, W 8'h40, W 8'hA5, STOP; dac_ready pulses once; busy 1 throughout, then 0.
- ADC ch=2, master returns 8'h11 then 8'h7C -> writes 8'h90, 8'h42, 8'h91; reads with nack 0 then 1; adc_rsp_valid pulse with adc_data=8'h7C.
- dac_valid and adc_valid both held high for 3 transactions -> order DAC, ADC, DAC; no overlap of command sequences.
- NACK on the address byte on first two attempts, ACK on third, MAX_RETRY=2 -> 3 full sequences, each NACK followed by STOP; transaction completes; err stays 0.
- NACK on every attempt, MAX_RETRY=2 -> 3 attempts, err pulses once, no adc_rsp_valid, back to IDLE accepting a new request.
- reset asserted while waiting for rsp of the control byte -> next cycle all outputs 0, state IDLE; a following DAC request completes normally.

Source files
------------

// File: rtl/pcf8591_pkg.sv
// Shared types for the PCF8591 transaction scheduler:
// command opcodes, FSM states, request types and sequence ROM entries.
package pcf8591_pkg;

    typedef enum logic [1:0] {
        OP_START = 2'd0,
        OP_WRITE = 2'd1,
        OP_READ  = 2'd2,
        OP_STOP  = 2'd3
    } op_e;

    localparam logic [7:0] CTRL_DAC_EN   = 8'h40;
    localparam logic [7:0] CTRL_ADC_BASE = 8'h40;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_NEXT,
        S_DONE,
        S_ERR_STOP
    } state_e;

    typedef enum logic {
        REQ_DAC = 1'b0,
        REQ_ADC = 1'b1
    } req_e;

    typedef enum logic [2:0] {
        WD_NONE,
        WD_ADDR_W,
        WD_ADDR_R,
        WD_DAC_CTRL,
        WD_ADC_CTRL,
        WD_DATA
    } wsel_e;

    typedef struct packed {
        op_e   op;
        wsel_e wsel;
        logic  nack;
        logic  last;
    } rom_t;

endpackage

// File: rtl/pcf8591_txn_scheduler_if.sv
// Byte-command bus between the scheduler (master) and the I2C byte master (slave).
interface pcf8591_txn_scheduler_if;

    logic       cmd_valid;
    logic [1:0] cmd_op;
    logic [7:0] cmd_wdata;
    logic       cmd_nack;
    logic       cmd_ready;
    logic       rsp_valid;
    logic       rsp_nack;
    logic [7:0] rsp_rdata;

    modport master (
        output cmd_valid, cmd_op, cmd_wdata, cmd_nack,
        input  cmd_ready, rsp_valid, rsp_nack, rsp_rdata
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_wdata, cmd_nack,
        output cmd_ready, rsp_valid, rsp_nack, rsp_rdata
    );

endinterface

// File: rtl/pcf8591_seq_rom.sv
// Maps (request type, step) to the byte command issued at that step,
// so the scheduler FSM stays generic.
module pcf8591_seq_rom
    import pcf8591_pkg::*;
(
    input  req_e       i_type,
    input  logic [2:0] i_step,
    output rom_t       o_ent
);

    always_comb begin
        o_ent = '{op: OP_STOP, wsel: WD_NONE, nack: 1'b0, last: 1'b1};
        if (i_type == REQ_DAC) begin
            case (i_step)
                3'd0: o_ent = '{OP_START, WD_NONE,     1'b0, 1'b0};
                3'd1: o_ent = '{OP_WRITE, WD_ADDR_W,   1'b0, 1'b0};
                3'd2: o_ent = '{OP_WRITE, WD_DAC_CTRL, 1'b0, 1'b0};
                3'd3: o_ent = '{OP_WRITE, WD_DATA,     1'b0, 1'b0};
                default: ;
            endcase
        end else begin
            // First READ returns the stale conversion and is discarded
            case (i_step)
                3'd0: o_ent = '{OP_START, WD_NONE,     1'b0, 1'b0};
                3'd1: o_ent = '{OP_WRITE, WD_ADDR_W,   1'b0, 1'b0};
                3'd2: o_ent = '{OP_WRITE, WD_ADC_CTRL, 1'b0, 1'b0};
                3'd3: o_ent = '{OP_START, WD_NONE,     1'b0, 1'b0};
                3'd4: o_ent = '{OP_WRITE, WD_ADDR_R,   1'b0, 1'b0};
                3'd5: o_ent = '{OP_READ,  WD_NONE,     1'b0, 1'b0};
                3'd6: o_ent = '{OP_READ,  WD_NONE,     1'b1, 1'b0};
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/pcf8591_txn_scheduler.sv
// Arbitrates DAC updates and ADC reads onto one PCF8591 and sequences
// byte-level I2C commands, retrying NACKed transactions.
module pcf8591_txn_scheduler
    import pcf8591_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR  = 7'h48,
    parameter int unsigned MAX_RETRY = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_dac_valid,
    input  logic [7:0] i_dac_data,
    output logic       o_dac_ready,
    input  logic       i_adc_valid,
    input  logic [1:0] i_adc_ch,
    output logic       o_adc_ready,
    output logic       o_adc_rsp_valid,
    output logic [7:0] o_adc_data,
    output logic       o_err,
    output logic       o_busy,
    pcf8591_txn_scheduler_if.master bus
);

    localparam logic [2:0] LP_MAX_RETRY = 3'(MAX_RETRY);

    state_e     r_state;
    state_e     w_state_nxt;
    req_e       r_type;
    req_e       r_rr_last;
    logic [2:0] r_step;
    logic [2:0] r_retry;
    logic       r_abort;
    logic [7:0] r_dac_data;
    logic [1:0] r_adc_ch;
    logic [7:0] r_rd_byte;
    logic [7:0] r_adc_data;

    rom_t       w_ent;
    logic [7:0] w_wdata;
    logic       w_dac_win;
    logic       w_adc_win;
    logic       w_accept;
    logic       w_wr_nack;
    logic       w_retry_ok;

    pcf8591_seq_rom u_rom (
        .i_type (r_type),
        .i_step (r_step),
        .o_ent  (w_ent)
    );

    // Round-robin: on a tie the type not served last wins
    assign w_dac_win  = i_dac_valid && (!i_adc_valid || r_rr_last == REQ_ADC);
    assign w_adc_win  = i_adc_valid && !w_dac_win;
    assign w_accept   = (r_state == S_IDLE) && (i_dac_valid || i_adc_valid);
    assign w_wr_nack  = bus.rsp_nack && (w_ent.op == OP_WRITE) && !r_abort;
    assign w_retry_ok = r_retry < LP_MAX_RETRY;

    assign o_busy     = (r_state != S_IDLE);
    assign o_adc_data = r_adc_data;

    always_comb begin
        w_wdata = 8'h00;
        case (w_ent.wsel)
            WD_ADDR_W:   w_wdata = {DEV_ADDR, 1'b0};
            WD_ADDR_R:   w_wdata = {DEV_ADDR, 1'b1};
            WD_DAC_CTRL: w_wdata = CTRL_DAC_EN;
            WD_ADC_CTRL: w_wdata = CTRL_ADC_BASE | {6'd0, r_adc_ch};
            WD_DATA:     w_wdata = r_dac_data;
            default:     w_wdata = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        o_dac_ready     = 1'b0;
        o_adc_ready     = 1'b0;
        o_adc_rsp_valid = 1'b0;
        o_err           = 1'b0;
        bus.cmd_valid   = 1'b0;
        bus.cmd_op      = 2'd0;
        bus.cmd_wdata   = 8'h00;
        bus.cmd_nack    = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_dac_ready = w_dac_win;
                o_adc_ready = w_adc_win;
                if (w_accept) w_state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                bus.cmd_valid = 1'b1;
                bus.cmd_op    = w_ent.op;
                bus.cmd_wdata = w_wdata;
                bus.cmd_nack  = w_ent.nack;
                if (bus.cmd_ready) w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (bus.rsp_valid) begin
                    if (r_abort) begin
                        w_state_nxt = w_retry_ok ? S_ISSUE : S_DONE;
                    end else if (w_wr_nack) begin
                        w_state_nxt = S_ERR_STOP;
                    end else if (w_ent.last) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_NEXT;
                    end
                end
            end
            S_NEXT: w_state_nxt = S_ISSUE;
            S_DONE: begin
                o_err           = r_abort;
                o_adc_rsp_valid = !r_abort && (r_type == REQ_ADC);
                w_state_nxt     = S_IDLE;
            end
            S_ERR_STOP: begin
                bus.cmd_valid = 1'b1;
                bus.cmd_op    = OP_STOP;
                if (bus.cmd_ready) w_state_nxt = S_WAIT;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_type     <= REQ_DAC;
            r_rr_last  <= REQ_ADC;
            r_step     <= 3'd0;
            r_retry    <= 3'd0;
            r_abort    <= 1'b0;
            r_dac_data <= 8'h00;
            r_adc_ch   <= 2'd0;
            r_rd_byte  <= 8'h00;
            r_adc_data <= 8'h00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_type    <= w_dac_win ? REQ_DAC : REQ_ADC;
                        r_rr_last <= w_dac_win ? REQ_DAC : REQ_ADC;
                        r_step    <= 3'd0;
                        r_retry   <= 3'd0;
                        r_abort   <= 1'b0;
                        if (w_dac_win) r_dac_data <= i_dac_data;
                        if (w_adc_win) r_adc_ch <= i_adc_ch;
                    end
                end
                S_WAIT: begin
                    if (bus.rsp_valid) begin
                        if (r_abort) begin
                            if (w_retry_ok) begin
                                r_retry <= r_retry + 3'd1;
                                r_step  <= 3'd0;
                                r_abort <= 1'b0;
                            end
                        end else if (w_wr_nack) begin
                            r_abort <= 1'b1;
                        end else begin
                            if (w_ent.op == OP_READ && w_ent.nack)
                                r_rd_byte <= bus.rsp_rdata;
                            if (w_ent.last && r_type == REQ_ADC)
                                r_adc_data <= r_rd_byte;
                        end
                    end
                end
                S_NEXT: r_step <= r_step + 3'd1;
                S_DONE: begin
                    r_retry <= 3'd0;
                    r_abort <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pcf8591_txn_scheduler.sv
// Directed bench for pcf8591_txn_scheduler: table of single transactions
// plus hand-written round-robin and mid-transaction reset sequences.
module tb_pcf8591_txn_scheduler;

    localparam int MAXR = 2;

    typedef struct {
        logic [1:0] op;
        logic [7:0] wd;
        logic       nk;
    } cmd_t;

    typedef struct {
        string      nm;
        bit         is_adc;
        logic [7:0] d;
        int         nacks;
        logic [7:0] rd0;
        logic [7:0] rd1;
        int         ncmd;
        int         adc_rsp;
        logic [7:0] exp_adc;
        int         exp_err;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       dac_valid;
    logic [7:0] dac_data;
    logic       dac_ready;
    logic       adc_valid;
    logic [1:0] adc_ch;
    logic       adc_ready;
    logic       adc_rsp_valid;
    logic [7:0] adc_data;
    logic       err;
    logic       busy;

    always #5 clk = ~clk;

    pcf8591_txn_scheduler_if bus ();

    pcf8591_txn_scheduler #(
        .DEV_ADDR  (7'h48),
        .MAX_RETRY (MAXR)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .i_dac_valid     (dac_valid),
        .i_dac_data      (dac_data),
        .o_dac_ready     (dac_ready),
        .i_adc_valid     (adc_valid),
        .i_adc_ch        (adc_ch),
        .o_adc_ready     (adc_ready),
        .o_adc_rsp_valid (adc_rsp_valid),
        .o_adc_data      (adc_data),
        .o_err           (err),
        .o_busy          (busy),
        .bus             (bus)
    );

    cmd_t       log_q[$];
    cmd_t       exp_q[$];
    int         acc_q[$];
    int         nack_limit = 0;
    int         nacks_given = 0;
    logic [7:0] rd0 = 8'h00;
    logic [7:0] rd1 = 8'h00;

    int n_dac_rdy = 0;
    int n_adc_rdy = 0;
    int n_adc_rsp = 0;
    int n_err = 0;
    int n_rdy_busy = 0;

    int n_chk = 0;
    int n_fail = 0;

    // I2C byte-master model: accepts at once, responds 2 cycles later.
    // Non-WRITE responses carry rsp_nack=1, which the DUT must ignore.
    initial begin : responder
        cmd_t       c;
        bit         hs;
        int         cnt;
        logic       nk;
        logic [7:0] rd;
        cnt = 0;
        nk = 1'b0;
        rd = 8'h00;
        bus.cmd_ready = 1'b1;
        bus.rsp_valid = 1'b0;
        bus.rsp_nack = 1'b0;
        bus.rsp_rdata = 8'h00;
        forever begin
            @(negedge clk);
            hs = bus.cmd_valid && bus.cmd_ready;
            c = '{bus.cmd_op, bus.cmd_wdata, bus.cmd_nack};
            @(posedge clk);
            #1;
            bus.rsp_valid = 1'b0;
            bus.rsp_nack = 1'b0;
            bus.rsp_rdata = 8'h00;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    bus.rsp_valid = 1'b1;
                    bus.rsp_nack = nk;
                    bus.rsp_rdata = rd;
                end
            end
            if (hs) begin
                log_q.push_back(c);
                cnt = 2;
                nk = 1'b1;
                rd = 8'hEE;
                if (c.op == 2'd1) begin
                    nk = 1'b0;
                    if (c.wd == 8'h90 && nacks_given < nack_limit) begin
                        nk = 1'b1;
                        nacks_given++;
                    end
                end else if (c.op == 2'd2) begin
                    rd = c.nk ? rd1 : rd0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (dac_ready) begin
            n_dac_rdy++;
            acc_q.push_back(0);
        end
        if (adc_ready) begin
            n_adc_rdy++;
            acc_q.push_back(1);
        end
        if ((dac_ready || adc_ready) && busy) n_rdy_busy++;
        if (adc_rsp_valid) n_adc_rsp++;
        if (err) n_err++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: timeout reached, got no finish, expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic cmd_t mk(logic [1:0] op, logic [7:0] wd, logic nk);
        cmd_t c;
        c.op = op;
        c.wd = wd;
        c.nk = nk;
        return c;
    endfunction

    // Only the fields meaningful for the opcode are compared
    function automatic logic [10:0] key(cmd_t c);
        return {c.op, (c.op == 2'd1) ? c.wd : 8'h00,
                (c.op == 2'd2) ? c.nk : 1'b0};
    endfunction

    function automatic void build_exp(bit is_adc, logic [7:0] d, int nacks);
        logic [7:0] ctl;
        ctl = 8'h40 | {6'd0, d[1:0]};
        for (int a = 0; a <= MAXR; a++) begin
            exp_q.push_back(mk(2'd0, 8'h00, 1'b0));
            exp_q.push_back(mk(2'd1, 8'h90, 1'b0));
            if (a < nacks) begin
                exp_q.push_back(mk(2'd3, 8'h00, 1'b0));
            end else begin
                if (!is_adc) begin
                    exp_q.push_back(mk(2'd1, 8'h40, 1'b0));
                    exp_q.push_back(mk(2'd1, d, 1'b0));
                end else begin
                    exp_q.push_back(mk(2'd1, ctl, 1'b0));
                    exp_q.push_back(mk(2'd0, 8'h00, 1'b0));
                    exp_q.push_back(mk(2'd1, 8'h91, 1'b0));
                    exp_q.push_back(mk(2'd2, 8'h00, 1'b0));
                    exp_q.push_back(mk(2'd2, 8'h00, 1'b1));
                end
                exp_q.push_back(mk(2'd3, 8'h00, 1'b0));
                break;
            end
        end
    endfunction

    function automatic vec_t mkv(string nm, bit is_adc, logic [7:0] d,
                                 int nacks, logic [7:0] r0, logic [7:0] r1,
                                 int ncmd, int arsp, logic [7:0] eadc,
                                 int eerr);
        vec_t v;
        v.nm = nm;
        v.is_adc = is_adc;
        v.d = d;
        v.nacks = nacks;
        v.rd0 = r0;
        v.rd1 = r1;
        v.ncmd = ncmd;
        v.adc_rsp = arsp;
        v.exp_adc = eadc;
        v.exp_err = eerr;
        return v;
    endfunction

    task automatic wait_ready(bit is_adc, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (is_adc ? adc_ready : dac_ready) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_cmds(string nm, int base, int ncmd);
        chk({nm, " ncmd"}, log_q.size() - base, ncmd);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < log_q.size())
                chk($sformatf("%s cmd%0d", nm, i), key(log_q[base + i]),
                    key(exp_q[i]));
        end
    endtask

    task automatic check_reset_outputs(string nm);
        chk({nm, " busy"}, busy, 0);
        chk({nm, " cmd_valid"}, bus.cmd_valid, 0);
        chk({nm, " cmd_fields"}, {bus.cmd_op, bus.cmd_wdata, bus.cmd_nack}, 0);
        chk({nm, " pulses"}, {err, adc_rsp_valid, dac_ready, adc_ready}, 0);
        chk({nm, " adc_data"}, adc_data, 0);
    endtask

    task automatic run_txn(vec_t v);
        int base;
        int s_d;
        int s_a;
        int s_r;
        int s_e;
        bit ok;
        base = log_q.size();
        s_d = n_dac_rdy;
        s_a = n_adc_rdy;
        s_r = n_adc_rsp;
        s_e = n_err;
        nack_limit = nacks_given + v.nacks;
        rd0 = v.rd0;
        rd1 = v.rd1;
        exp_q.delete();
        build_exp(v.is_adc, v.d, v.nacks);
        @(posedge clk);
        #1;
        if (v.is_adc) begin
            adc_valid = 1'b1;
            adc_ch = v.d[1:0];
        end else begin
            dac_valid = 1'b1;
            dac_data = v.d;
        end
        wait_ready(v.is_adc, ok);
        chk({v.nm, " accept"}, ok, 1);
        @(posedge clk);
        #1;
        dac_valid = 1'b0;
        adc_valid = 1'b0;
        wait_idle(ok);
        chk({v.nm, " idle"}, ok, 1);
        check_cmds(v.nm, base, v.ncmd);
        chk({v.nm, " dac_ready"}, n_dac_rdy - s_d, v.is_adc ? 0 : 1);
        chk({v.nm, " adc_ready"}, n_adc_rdy - s_a, v.is_adc ? 1 : 0);
        chk({v.nm, " adc_rsp"}, n_adc_rsp - s_r, v.adc_rsp);
        chk({v.nm, " adc_data"}, adc_data, v.exp_adc);
        chk({v.nm, " err"}, n_err - s_e, v.exp_err);
    endtask

    vec_t tbl[6];

    initial begin : main
        int base;
        int a0;
        int s_r;
        int s_rb;
        bit ok;

        tbl[0] = mkv("dac_a5",      0, 8'hA5, 0, 8'h00, 8'h00,  5, 0, 8'h66, 0);
        tbl[1] = mkv("adc_ch2",     1, 8'h02, 0, 8'h11, 8'h7C,  8, 1, 8'h7C, 0);
        tbl[2] = mkv("adc_retry",   1, 8'h01, 2, 8'h22, 8'h33, 14, 1, 8'h33, 0);
        tbl[3] = mkv("dac_abandon", 0, 8'h3C, 3, 8'h00, 8'h00,  9, 0, 8'h33, 1);
        tbl[4] = mkv("adc_abandon", 1, 8'h03, 7, 8'h44, 8'h55,  9, 0, 8'h33, 1);
        tbl[5] = mkv("dac_after",   0, 8'h00, 0, 8'h00, 8'h00,  5, 0, 8'h33, 0);

        reset = 1'b1;
        dac_valid = 1'b0;
        dac_data = 8'h00;
        adc_valid = 1'b0;
        adc_ch = 2'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("por");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Both requesters held: DAC wins first tie, then alternate
        base = log_q.size();
        a0 = acc_q.size();
        s_r = n_adc_rsp;
        s_rb = n_rdy_busy;
        nack_limit = nacks_given;
        rd0 = 8'h55;
        rd1 = 8'h66;
        exp_q.delete();
        build_exp(0, 8'h81, 0);
        build_exp(1, 8'h00, 0);
        build_exp(0, 8'h81, 0);
        @(posedge clk);
        #1;
        dac_valid = 1'b1;
        dac_data = 8'h81;
        adc_valid = 1'b1;
        adc_ch = 2'd0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (acc_q.size() - a0 >= 3) break;
        end
        @(posedge clk);
        #1;
        dac_valid = 1'b0;
        adc_valid = 1'b0;
        wait_idle(ok);
        chk("rr idle", ok, 1);
        chk("rr accepts", acc_q.size() - a0, 3);
        if (acc_q.size() - a0 >= 3) begin
            chk("rr order0", acc_q[a0], 0);
            chk("rr order1", acc_q[a0 + 1], 1);
            chk("rr order2", acc_q[a0 + 2], 0);
        end
        check_cmds("rr", base, 18);
        chk("rr ready_busy", n_rdy_busy - s_rb, 0);
        chk("rr adc_rsp", n_adc_rsp - s_r, 1);
        chk("rr adc_data", adc_data, 8'h66);

        for (int i = 0; i < 6; i++) run_txn(tbl[i]);

        // Reset while the DAC control byte's response is outstanding
        base = log_q.size();
        nack_limit = nacks_given;
        @(posedge clk);
        #1;
        dac_valid = 1'b1;
        dac_data = 8'h5A;
        wait_ready(0, ok);
        chk("rst accept", ok, 1);
        @(posedge clk);
        #1;
        dac_valid = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (log_q.size() - base >= 3) begin
                ok = 1'b1;
                break;
            end
        end
        chk("rst reach_ctrl", ok, 1);
        if (log_q.size() - base >= 3)
            chk("rst ctrl_byte", key(log_q[base + 2]), key(mk(2'd1, 8'h40, 1'b0)));
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (5) @(posedge clk);
        run_txn(mkv("dac_post_rst", 0, 8'h5A, 0, 8'h00, 8'h00, 5, 0, 8'h00, 0));

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
